// File: rtl/cell_counter_dffr.sv
// Stdcell flop with asynchronous active-low clear, the resettable companion of
// the plain edge-triggered flop cell.
module dffr (
   input  logic D,
   input  logic CLK,
   input  logic RST_N,
   output logic Q
);

   logic q_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q_q <= 1'b0;
      end else begin
         q_q <= D;
      end
   end

   assign Q = q_q;

endmodule

// File: rtl/cell_counter.sv
// Loadable up/down counter assembled from dffr cells, a toggle chain, a per-bit
// load mux and a terminal-count detect.
module cell_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             LOAD,
   input  logic             UP,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   // eq[i] is high when bit i already sits at the direction's carry value
   logic [WIDTH-1:0] eq;
   logic             load_n;

   assign load_n = ~LOAD;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic toggle;
      logic count_nx;

      assign eq[i] = ~(count_q[i] ^ UP);

      if (i == 0) begin : g_lsb
         assign toggle = EN;
      end else begin : g_upper
         assign toggle = EN & (&eq[i-1:0]);
      end

      assign count_nx   = count_q[i] ^ toggle;
      assign count_d[i] = (LOAD & D[i]) | (load_n & count_nx);

      dffr u_ff (
         .D     (count_d[i]),
         .CLK   (CLK),
         .RST_N (RST_N),
         .Q     (count_q[i])
      );
   end

   // High in the cycle before a wrap so TC can feed the next stage's EN
   assign TC = EN & load_n & (&eq);
   assign Q  = count_q;

endmodule
